shiftreg_en: RTL

SHIFTREG_EN -- requirements
Module: shiftreg_en

---
 rtl/shiftreg_en.sv | 88 ++++++++
 1 files changed

// File: rtl/shiftreg_en.sv
// shiftreg_en: WIDTH-bit shift register with IDLE-mode operations and a serial transfer FSM.
// Ports:
//   CLK   - clock, all state updates on rising edge
//   RST   - asynchronous active-high reset
//   En    - clock enable, 0 freezes Q, counter and FSM
//   Mode  - IDLE operation select (hold/load/shl/shr/rotl/rotr)
//   D     - parallel load data
//   SIn   - serial input bit
//   Start - begin a WIDTH-bit serial transfer (LSB first on SOut)
//   Q     - register contents
//   SOut  - serial output, equal to Q[0]
//   Busy  - high while shifting out
//   Done  - one enabled cycle pulse after the last shift
module shiftreg_en #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SIn,
    input  logic             Start,
    output logic [WIDTH-1:0] Q,
    output logic             SOut,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] q_q, q_d, shr_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q;
    assign shr_d = {SIn, q_q[WIDTH-1:1]};
    always_comb begin
        q_d = Mode == 3'd1 ? D :
              Mode == 3'd2 ? {q_q[WIDTH-2:0], SIn} :
              Mode == 3'd3 ? shr_d :
              Mode == 3'd4 ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} :
              Mode == 3'd5 ? {q_q[0], q_q[WIDTH-1:1]} : q_q;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (En) begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        q_q     <= D;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end else begin
                        q_q <= q_d;
                    end
                end
                SHIFT: begin
                    q_q   <= shr_d;
                    cnt_q <= cnt_q + 1'b1;
                    // this edge performs the WIDTH-th shift
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
    assign Q    = q_q;
    assign SOut = q_q[0];
    assign Busy = busy_q;
    assign Done = done_q;
endmodule
